// File: rtl/text_writer.sv
// text_writer: ASCII byte stream to text-memory writes with cursor tracking; TEXT_WRITER_RESET_CLEAR_EN makes reset start a full-screen clear
module text_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int ADDR_W = 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        char_data,
  input  logic              char_valid,
  output logic              char_ready,
  output logic [7:0]        write_data,
  output logic [ADDR_W-1:0] write_address,
  output logic              write_enable,
  output logic [6:0]        cursor_x,
  output logic [5:0]        cursor_y,
  output logic              busy
);
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam int CW = ADDR_W + 1;
  localparam logic [6:0] X_MAX = 7'(COLS - 1);
  localparam logic [5:0] Y_MAX = 6'(ROWS - 1);
  localparam logic [CW-1:0] CELLS = CW'(COLS * ROWS);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);
  localparam logic [7:0] CR = 8'h0d, LF = 8'h0a, BS = 8'h08, FF = 8'h0c;
`ifdef TEXT_WRITER_RESET_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif
  state_t state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic [CW-1:0] cnt;
  logic accept, printable, last_col, last_row, clear_done;
  assign char_ready = state == IDLE;
  assign busy = state == CLEAR;
  assign accept = char_valid && char_ready;
  assign printable = char_data >= 8'h20 && char_data <= 8'h7e;
  assign last_col = cursor_x == X_MAX;
  assign last_row = cursor_y == Y_MAX;
  // the clear counter runs one past the last cell so ready stays low through the final clear write
  assign clear_done = cnt == CELLS;
  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= RESET_STATE;
    else state <= state_next;
  // FF starts a clear; a finished clear returns to accepting bytes
  always_comb begin
    state_next = (accept && char_data == FF) ? CLEAR : (busy && clear_done) ? IDLE : state;
  end
  // cursor, linear pointer and registered write port; ptr tracks y*COLS+x without a multiplier
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cursor_x <= '0;
      cursor_y <= '0;
      ptr <= '0;
      cnt <= '0;
      write_enable <= 1'b0;
      write_data <= '0;
      write_address <= '0;
    end else begin
      write_enable <= 1'b0;
      if (busy) begin
        if (!clear_done) begin
          write_enable <= 1'b1;
          write_data <= 8'h20;
          write_address <= cnt[ADDR_W-1:0];
          cnt <= cnt + 1'b1;
        end
      end else if (accept) begin
        if (printable) begin
          write_enable <= 1'b1;
          write_data <= char_data;
          write_address <= ptr;
          cursor_x <= last_col ? '0 : cursor_x + 1'b1;
          cursor_y <= last_col ? (last_row ? '0 : cursor_y + 1'b1) : cursor_y;
          ptr <= (last_col && last_row) ? '0 : ptr + 1'b1;
        end else if (char_data == CR) begin
          cursor_x <= '0;
          ptr <= ptr - ADDR_W'(cursor_x);
        end else if (char_data == LF) begin
          cursor_x <= '0;
          cursor_y <= last_row ? '0 : cursor_y + 1'b1;
          ptr <= last_row ? '0 : ptr - ADDR_W'(cursor_x) + ROW_STEP;
        end else if (char_data == BS) begin
          if (cursor_x != '0) begin
            cursor_x <= cursor_x - 1'b1;
            ptr <= ptr - 1'b1;
          end
        end else if (char_data == FF) begin
          cursor_x <= '0;
          cursor_y <= '0;
          ptr <= '0;
          cnt <= '0;
        end
      end
    end
endmodule

// File: tb/tb_text_writer.sv
// tb_text_writer: directed and random byte streams against a cursor/screen model of text_writer
module tb_text_writer;
  localparam int COLS = 80, ROWS = 60, AW = 13, CELLS = COLS * ROWS;
  logic clock = 1'b0, reset = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic char_valid = 1'b0;
  logic char_ready, write_enable, busy;
  logic [7:0] write_data;
  logic [AW-1:0] write_address;
  logic [6:0] cursor_x;
  logic [5:0] cursor_y;
  int vectors = 0, miscompares = 0;
  int cyc = 0, ready_hi = 0;
  int got_addr[$], got_data[$], got_cyc[$];
  int exp_addr[$], exp_data[$];
  int mx = 0, my = 0;
  text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .write_data(write_data), .write_address(write_address),
    .write_enable(write_enable), .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock)
    if (write_enable) begin
      got_addr.push_back(int'(write_address));
      got_data.push_back(int'(write_data));
      got_cyc.push_back(cyc);
      if (char_ready) ready_hi++;
    end
  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) begin
      exp_addr.push_back(i);
      exp_data.push_back(32);
    end
    mx = 0;
    my = 0;
  endtask
  task automatic model(input int b);
    if (b >= 32 && b <= 126) begin
      exp_addr.push_back(my * COLS + mx);
      exp_data.push_back(b);
      mx++;
      if (mx == COLS) begin
        mx = 0;
        my = (my + 1) % ROWS;
      end
    end else if (b == 13) mx = 0;
    else if (b == 10) begin
      mx = 0;
      my = (my + 1) % ROWS;
    end else if (b == 8) begin
      if (mx > 0) mx--;
    end else if (b == 12) model_clear();
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!char_ready && n < CELLS + 100) begin
      step();
      n++;
    end
    if (!char_ready) chk("send_ready", int'(char_ready), 1);
    char_data = b;
    char_valid = 1'b1;
    step();
    char_valid = 1'b0;
    model(int'(b));
  endtask
  task automatic drain();
    int n = 0;
    while (!char_ready && n < CELLS + 100) begin
      step();
      n++;
    end
    if (!char_ready) chk("drain_ready", int'(char_ready), 1);
    repeat (2) step();
  endtask
  task automatic verify(input string tag);
    int n;
    drain();
    chk({tag, " count"}, got_addr.size(), exp_addr.size());
    n = got_addr.size() < exp_addr.size() ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, " addr"}, got_addr[i], exp_addr[i]);
      chk({tag, " data"}, got_data[i], exp_data[i]);
    end
    chk({tag, " cursor_x"}, int'(cursor_x), mx);
    chk({tag, " cursor_y"}, int'(cursor_y), my);
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask
  initial begin
    int r, last;
    #2;
    chk("rst write_enable", int'(write_enable), 0);
    chk("rst write_data", int'(write_data), 0);
    chk("rst write_address", int'(write_address), 0);
    chk("rst cursor_x", int'(cursor_x), 0);
    chk("rst cursor_y", int'(cursor_y), 0);
`ifdef TEXT_WRITER_RESET_CLEAR_EN
    chk("rst char_ready", int'(char_ready), 0);
    chk("rst busy", int'(busy), 1);
`else
    chk("rst char_ready", int'(char_ready), 1);
    chk("rst busy", int'(busy), 0);
`endif
    step();
    reset = 1'b1;
`ifdef TEXT_WRITER_RESET_CLEAR_EN
    model_clear();
    step();
    chk("auto clear busy", int'(busy), 1);
    chk("auto clear first we", int'(write_enable), 1);
    verify("auto clear");
`endif
    send("A");
    send("B");
    drain();
    chk("AB back to back", got_cyc.size() == 2 ? got_cyc[1] - got_cyc[0] : -1, 1);
    verify("AB");
    for (int i = 0; i < 59; i++) send(8'h0a);
    send(8'h0d);
    for (int i = 0; i < 79; i++) send(8'($urandom_range(32, 126)));
    verify("to corner");
    send("Z");
    verify("corner wrap");
    chk("corner addr", (my == 0 && mx == 0) ? int'(write_address) : -1, 4799);
    send(8'h0d);
    verify("CR at x0");
    send("a");
    send("b");
    send(8'h08);
    send(8'h08);
    send(8'h08);
    send("c");
    verify("backspace");
    for (int i = 0; i < 3; i++) send(8'h0a);
    for (int i = 0; i < 5; i++) send(8'($urandom_range(32, 126)));
    verify("to 5,3");
    send(8'h0a);
    verify("LF");
    send(8'h07);
    verify("BEL ignored");
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) send(8'($urandom_range(32, 126)));
      else if (r == 6) send(8'h0d);
      else if (r == 7) send(8'h0a);
      else if (r == 8) send(8'h08);
      else send($urandom_range(0, 1) ? 8'h7f : 8'($urandom_range(128, 255)));
      if ($urandom_range(0, 3) == 0) step();
      if (i % 25 == 24) verify("random");
    end
    verify("random end");
    ready_hi = 0;
    send(8'h0c);
    chk("FF ready low", int'(char_ready), 0);
    chk("FF busy", int'(busy), 1);
    drain();
    last = got_cyc.size() - 1;
    chk("FF consecutive", last >= 0 ? got_cyc[last] - got_cyc[0] : -1, CELLS - 1);
    chk("FF ready during writes", ready_hi, 0);
    verify("FF clear");
    send("Q");
    verify("after clear");
    send(8'h0c);
    r = 0;
    while (got_addr.size() < 100 && r < 400) begin
      @(negedge clock);
      r++;
    end
    chk("reach clear write 100", got_addr.size(), 100);
    reset = 1'b0;
    #1;
    chk("midclear we", int'(write_enable), 0);
    chk("midclear data", int'(write_data), 0);
    chk("midclear addr", int'(write_address), 0);
    chk("midclear cursor_x", int'(cursor_x), 0);
`ifdef TEXT_WRITER_RESET_CLEAR_EN
    chk("midclear busy", int'(busy), 1);
`else
    chk("midclear busy", int'(busy), 0);
    chk("midclear ready", int'(char_ready), 1);
`endif
    repeat (3) step();
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    exp_addr.delete();
    exp_data.delete();
    mx = 0;
    my = 0;
    reset = 1'b1;
`ifdef TEXT_WRITER_RESET_CLEAR_EN
    model_clear();
`else
    repeat (20) step();
`endif
    verify("after midclear reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
